// File: rtl/axi_rd_arbiter.sv
// Two-requester AXI4 read arbiter: round-robin grant, one outstanding burst,
// per-requester data steering and sticky protocol / 4KB-crossing error flags.
module axi_rd_arbiter #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [7:0]            len0,
    input  logic [7:0]            len1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic                  rlast0,
    output logic                  rlast1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rerr0,
    output logic                  rerr1,
    output logic [ID_WIDTH-1:0]   arid_m_inf,
    output logic [ADDR_WIDTH-1:0] araddr_m_inf,
    output logic [7:0]            arlen_m_inf,
    output logic [2:0]            arsize_m_inf,
    output logic [1:0]            arburst_m_inf,
    output logic                  arvalid_m_inf,
    input  logic                  arready_m_inf,
    input  logic [ID_WIDTH-1:0]   rid_m_inf,
    input  logic [DATA_WIDTH-1:0] rdata_m_inf,
    input  logic [1:0]            rresp_m_inf,
    input  logic                  rlast_m_inf,
    input  logic                  rvalid_m_inf,
    output logic                  rready_m_inf
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic                  idx_q, idx_d;
    logic                  rr_last_q, rr_last_d;
    logic [8:0]            beat_q, beat_d;
    logic                  rerr0_q, rerr0_d;
    logic                  rerr1_q, rerr1_d;

    logic                  win_s;
    logic [ADDR_WIDTH-1:0] win_addr_s;
    logic [7:0]            win_len_s;
    logic                  err_s;
    logic                  err_idx_s;
    logic                  beat_s;
    logic [ID_WIDTH-1:0]   arid_s;

    // A burst of 16-byte beats must end at or before the next 4KB boundary.
    function automatic logic crosses_4k(input logic [11:0] offs, input logic [7:0] len);
        logic [12:0] span_end;
        span_end = {1'b0, offs} + {1'b0, len, 4'b0000} + 13'd16;
        return span_end > 13'd4096;
    endfunction

    function automatic logic beat_bad(input logic [1:0] resp, input logic id_ok,
                                      input logic last, input logic [8:0] beat_num,
                                      input logic [7:0] len);
        logic at_end;
        at_end = (beat_num == ({1'b0, len} + 9'd1));
        return (resp != 2'b00) || !id_ok || (last != at_end);
    endfunction

    // Zero-extended requester index used as the AXI transaction ID.
    always_comb begin
        arid_s    = '0;
        arid_s[0] = idx_q;
    end

    // Round-robin pick: on a tie the requester not granted last wins.
    always_comb begin
        if (req0 && req1) begin
            win_s = ~rr_last_q;
        end else begin
            win_s = req1;
        end
        win_addr_s = win_s ? addr1 : addr0;
        win_len_s  = win_s ? len1 : len0;
    end

    // Next-state and error detection.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        idx_d     = idx_q;
        rr_last_d = rr_last_q;
        beat_d    = beat_q;
        err_s     = 1'b0;
        err_idx_s = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    addr_d    = win_addr_s;
                    len_d     = win_len_s;
                    idx_d     = win_s;
                    beat_d    = 9'd0;
                    err_s     = crosses_4k(win_addr_s[11:0], win_len_s);
                    err_idx_s = win_s;
                    state_d   = ST_ADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (arready_m_inf) begin
                    rr_last_d = idx_q;
                    state_d   = ST_DATA;
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (rvalid_m_inf) begin
                    beat_d = beat_q + 9'd1;
                    err_s  = beat_bad(rresp_m_inf, rid_m_inf == arid_s, rlast_m_inf,
                                      beat_q + 9'd1, len_q);
                    if (rlast_m_inf) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        rerr0_d = rerr0_q | (err_s & ~err_idx_s);
        rerr1_d = rerr1_q | (err_s & err_idx_s);
    end

    // State and context registers; error flags clear only on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            len_q     <= 8'd0;
            idx_q     <= 1'b0;
            rr_last_q <= 1'b1;
            beat_q    <= 9'd0;
            rerr0_q   <= 1'b0;
            rerr1_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            rr_last_q <= rr_last_d;
            beat_q    <= beat_d;
            rerr0_q   <= rerr0_d;
            rerr1_q   <= rerr1_d;
        end
    end

    assign arvalid_m_inf = (state_q == ST_ADDR);
    assign rready_m_inf  = (state_q == ST_DATA);
    assign beat_s        = rready_m_inf && rvalid_m_inf;

    assign gnt0    = arvalid_m_inf && arready_m_inf && !idx_q;
    assign gnt1    = arvalid_m_inf && arready_m_inf && idx_q;
    assign rvalid0 = beat_s && !idx_q;
    assign rvalid1 = beat_s && idx_q;
    assign rlast0  = beat_s && rlast_m_inf && !idx_q;
    assign rlast1  = beat_s && rlast_m_inf && idx_q;
    assign rdata   = rdata_m_inf;
    assign rerr0   = rerr0_q;
    assign rerr1   = rerr1_q;

    assign arid_m_inf    = arid_s;
    assign araddr_m_inf  = addr_q;
    assign arlen_m_inf   = len_q;
    assign arsize_m_inf  = 3'b100;
    assign arburst_m_inf = 2'b01;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: the stimulus side acts as both requesters
// and the AXI slave, a negedge monitor pops expected AR/beat records and compares.
module tb_axi_rd_arbiter;
    localparam int IDW = 4;
    localparam int AW  = 32;
    localparam int DW  = 128;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           req0 = 1'b0, req1 = 1'b0;
    logic [AW-1:0]  addr0 = '0, addr1 = '0;
    logic [7:0]     len0 = 8'd0, len1 = 8'd0;
    logic           gnt0, gnt1, rvalid0, rvalid1, rlast0, rlast1, rerr0, rerr1;
    logic [DW-1:0]  rdata;
    logic [IDW-1:0] arid_m_inf;
    logic [AW-1:0]  araddr_m_inf;
    logic [7:0]     arlen_m_inf;
    logic [2:0]     arsize_m_inf;
    logic [1:0]     arburst_m_inf;
    logic           arvalid_m_inf, rready_m_inf;
    logic           arready_m_inf = 1'b0;
    logic [IDW-1:0] rid_m_inf = '0;
    logic [DW-1:0]  rdata_m_inf = '0;
    logic [1:0]     rresp_m_inf = 2'b00;
    logic           rlast_m_inf = 1'b0;
    logic           rvalid_m_inf = 1'b0;

    always #5 clk = ~clk;

    axi_rd_arbiter #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1), .len0(len0), .len1(len1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rlast0(rlast0), .rlast1(rlast1), .rdata(rdata), .rerr0(rerr0), .rerr1(rerr1),
        .arid_m_inf(arid_m_inf), .araddr_m_inf(araddr_m_inf), .arlen_m_inf(arlen_m_inf),
        .arsize_m_inf(arsize_m_inf), .arburst_m_inf(arburst_m_inf),
        .arvalid_m_inf(arvalid_m_inf), .arready_m_inf(arready_m_inf),
        .rid_m_inf(rid_m_inf), .rdata_m_inf(rdata_m_inf), .rresp_m_inf(rresp_m_inf),
        .rlast_m_inf(rlast_m_inf), .rvalid_m_inf(rvalid_m_inf), .rready_m_inf(rready_m_inf)
    );

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [AW-1:0]  addr;
        logic [7:0]     len;
    } ar_t;

    typedef struct packed {
        logic          idx;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    ar_t            ar_q[$];
    beat_t          beat_q[$];
    logic [IDW-1:0] gnt_hist[$];
    int             n_checks = 0;
    int             n_fail = 0;

    // Reference model state: pending requests, last grant, expected sticky errors.
    bit             pend[2];
    logic [AW-1:0]  p_addr[2];
    logic [7:0]     p_len[2];
    int             last_gnt = 1;
    bit             exp_rerr[2];

    ar_t            m_ar;
    beat_t          m_bt;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic finish_test();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    function automatic int model_winner();
        if (pend[0] && pend[1]) return (last_gnt == 0) ? 1 : 0;
        else if (pend[0]) return 0;
        else return 1;
    endfunction

    task automatic drive_req(input int i, input logic v);
        if (i == 0) req0 = v;
        else req1 = v;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [7:0] l);
        pend[i] = 1'b1;
        p_addr[i] = a;
        p_len[i] = l;
        if (i == 0) begin addr0 = a; len0 = l; end
        else begin addr1 = a; len1 = l; end
        drive_req(i, 1'b1);
    endtask

    task automatic model_reset();
        pend[0] = 1'b0; pend[1] = 1'b0;
        exp_rerr[0] = 1'b0; exp_rerr[1] = 1'b0;
        last_gnt = 1;
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_gnt", 128'({gnt1, gnt0}), 128'(0));
        check("rst_rvalid", 128'({rvalid1, rvalid0}), 128'(0));
        check("rst_rlast", 128'({rlast1, rlast0}), 128'(0));
        check("rst_arvalid", 128'(arvalid_m_inf), 128'(0));
        check("rst_rready", 128'(rready_m_inf), 128'(0));
        check("rst_rerr", 128'({rerr1, rerr0}), 128'(0));
        check("rst_araddr", 128'(araddr_m_inf), 128'(0));
        check("rst_arlen", 128'(arlen_m_inf), 128'(0));
        check("rst_arid", 128'(arid_m_inf), 128'(0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Serve one burst for the model-predicted winner acting as the AXI slave.
    task automatic serve(input int ar_delay, input int beat_delta, input int bad_resp_beat,
                         input int bad_id_beat, input int reset_at_beat, input bit drop_early);
        int            w, nbeats, cyc, off;
        ar_t           e;
        beat_t         b;
        logic [DW-1:0] d;
        w = model_winner();
        e.id = 4'(w);
        e.addr = p_addr[w];
        e.len = p_len[w];
        ar_q.push_back(e);
        off = int'(p_addr[w] & 32'h0000_0FFF);
        if (off + 16 * (int'(p_len[w]) + 1) > 4096) exp_rerr[w] = 1'b1;
        nbeats = int'(p_len[w]) + 1 + beat_delta;
        if (nbeats < 1) nbeats = 1;
        if (nbeats != int'(p_len[w]) + 1) exp_rerr[w] = 1'b1;
        cyc = 0;
        while (!arvalid_m_inf) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc > 50) begin
                n_checks++;
                n_fail++;
                $display("FAIL ar_timeout: arvalid 0 after 50 cycles, expected 1");
                finish_test();
                return;
            end
        end
        if (drop_early) drive_req(w, 1'b0);
        for (int k = 0; k < ar_delay; k++) begin
            @(posedge clk);
            #1;
            check("arvalid_hold", 128'(arvalid_m_inf), 128'(1));
            check("araddr_hold", 128'(araddr_m_inf), 128'(e.addr));
        end
        arready_m_inf = 1'b1;
        @(posedge clk);
        #1;
        arready_m_inf = 1'b0;
        drive_req(w, 1'b0);
        pend[w] = 1'b0;
        last_gnt = w;
        for (int k = 1; k <= nbeats; k++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            d = {$urandom, $urandom, $urandom, $urandom};
            rdata_m_inf = d;
            rid_m_inf = 4'(w);
            rlast_m_inf = (k == nbeats);
            if (k == reset_at_beat) begin
                rvalid_m_inf = 1'b1;
                rst_n = 1'b0;
                #1;
                check_reset_outputs();
                model_reset();
                rvalid_m_inf = 1'b0;
                rlast_m_inf = 1'b0;
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
                return;
            end
            check("rready", 128'(rready_m_inf), 128'(1));
            rresp_m_inf = (k == bad_resp_beat) ? 2'b10 : 2'b00;
            if (k == bad_id_beat) rid_m_inf = 4'(1 - w);
            if (k == bad_resp_beat || k == bad_id_beat) exp_rerr[w] = 1'b1;
            b.idx = (w == 1);
            b.data = d;
            b.last = (k == nbeats);
            beat_q.push_back(b);
            rvalid_m_inf = 1'b1;
            @(posedge clk);
            #1;
            rvalid_m_inf = 1'b0;
            rlast_m_inf = 1'b0;
            rresp_m_inf = 2'b00;
        end
        check("rready_after_last", 128'(rready_m_inf), 128'(0));
        check("rerr0", 128'(rerr0), 128'(exp_rerr[0]));
        check("rerr1", 128'(rerr1), 128'(exp_rerr[1]));
    endtask

    // Monitor: compare every AR handshake and every delivered beat with the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (arvalid_m_inf && arready_m_inf) begin
                if (ar_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL ar_unexpected: got arid 0x%0h expected no request", arid_m_inf);
                end else begin
                    m_ar = ar_q.pop_front();
                    gnt_hist.push_back(arid_m_inf);
                    check("arid", 128'(arid_m_inf), 128'(m_ar.id));
                    check("araddr", 128'(araddr_m_inf), 128'(m_ar.addr));
                    check("arlen", 128'(arlen_m_inf), 128'(m_ar.len));
                    check("arsize", 128'(arsize_m_inf), 128'(3'b100));
                    check("arburst", 128'(arburst_m_inf), 128'(2'b01));
                    check("gnt0", 128'(gnt0), 128'(m_ar.id == 4'd0));
                    check("gnt1", 128'(gnt1), 128'(m_ar.id == 4'd1));
                end
            end else if (gnt0 || gnt1) begin
                check("gnt_spurious", 128'({gnt1, gnt0}), 128'(0));
            end
            if (rvalid0 || rvalid1) begin
                if (beat_q.size() == 0) begin
                    check("beat_unexpected", 128'({rvalid1, rvalid0}), 128'(0));
                end else begin
                    m_bt = beat_q.pop_front();
                    check("rvalid_sel", 128'({rvalid1, rvalid0}), m_bt.idx ? 128'(2) : 128'(1));
                    check("rdata", rdata, m_bt.data);
                    check("rlast", 128'({rlast1, rlast0}),
                          m_bt.last ? (m_bt.idx ? 128'(2) : 128'(1)) : 128'(0));
                end
            end else if (rlast0 || rlast1) begin
                check("rlast_spurious", 128'({rlast1, rlast0}), 128'(0));
            end
        end
    end

    initial begin
        #1_000_000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached before end of stimulus");
        finish_test();
    end

    initial begin
        logic [1:0] sel;
        int         dl, br, bi;
        model_reset();
        #1;
        do_reset();

        // Simultaneous requests twice: grant order must be 0,1,0,1.
        gnt_hist.delete();
        set_req(0, 32'h0000_2000, 8'd3);
        set_req(1, 32'h0000_3000, 8'd2);
        serve(1, 0, 0, 0, 0, 1'b0);
        serve(0, 0, 0, 0, 0, 1'b0);
        set_req(0, 32'h0000_2100, 8'd1);
        set_req(1, 32'h0000_3100, 8'd0);
        serve(2, 0, 0, 0, 0, 1'b0);
        serve(0, 0, 0, 0, 0, 1'b0);
        check("rr_count", 128'(gnt_hist.size()), 128'(4));
        for (int i = 0; i < 4; i++) begin
            if (i < gnt_hist.size()) check("rr_order", 128'(gnt_hist[i]), 128'(i % 2));
        end

        // Long burst: 256 beats, arready after 3 cycles.
        set_req(0, 32'h0000_1000, 8'd255);
        serve(3, 0, 0, 0, 0, 1'b0);

        // Early rlast on beat 2 of a 4-beat burst.
        set_req(0, 32'h0000_4000, 8'd3);
        serve(1, -2, 0, 0, 0, 1'b0);

        // Reset during beat 10 of a 4KB-crossing burst, then both request.
        set_req(0, 32'h0000_0F80, 8'd15);
        serve(0, 0, 0, 0, 10, 1'b0);
        set_req(0, 32'h0000_5000, 8'd7);
        set_req(1, 32'h0000_7000, 8'd2);
        serve(1, 0, 0, 0, 0, 1'b0);
        serve(1, 0, 0, 0, 0, 1'b0);

        // 4KB crossing on requester 1: still issued unchanged.
        set_req(1, 32'h0000_0FF0, 8'd1);
        serve(0, 0, 0, 0, 0, 1'b0);

        // Error response on beat 2, then a clean burst: flag stays set.
        do_reset();
        set_req(1, 32'h0000_6000, 8'd3);
        serve(2, 0, 2, 0, 0, 1'b0);
        set_req(1, 32'h0000_6100, 8'd1);
        serve(0, 0, 0, 0, 0, 1'b0);

        // Wrong RID, missing rlast, and request dropped while AR is pending.
        do_reset();
        set_req(0, 32'h0000_8000, 8'd3);
        serve(0, 0, 0, 3, 0, 1'b0);
        do_reset();
        set_req(0, 32'h0000_9000, 8'd2);
        serve(1, 1, 0, 0, 0, 1'b0);
        do_reset();
        set_req(0, 32'h0000_A000, 8'd1);
        serve(2, 0, 0, 0, 0, 1'b1);

        // Randomized traffic.
        for (int r = 0; r < 24; r++) begin
            if (r % 6 == 0) do_reset();
            sel = 2'($urandom_range(1, 3));
            for (int i = 0; i < 2; i++) begin
                if (sel[i]) set_req(i, $urandom & 32'hFFFF_FFF0, 8'($urandom_range(0, 15)));
            end
            while (pend[0] || pend[1]) begin
                dl = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2)) - 1 : 0;
                br = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0;
                bi = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 4)) : 0;
                serve(int'($urandom_range(0, 3)), dl, br, bi, 0, 1'b0);
            end
        end

        repeat (5) @(posedge clk);
        #1;
        check("ar_q_empty", 128'(ar_q.size()), 128'(0));
        check("beat_q_empty", 128'(beat_q.size()), 128'(0));
        finish_test();
    end

endmodule

// File: doc/axi_rd_arbiter.md
AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 SHALL have parameter ID_WIDTH, 4, AXI ID width.
REQ-002 SHALL have parameter ADDR_WIDTH, 32, AXI address width.
REQ-003 SHALL have parameter DATA_WIDTH, 128, AXI data width.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req0, req1  input  1 each  read-burst request from pixel loader (0) and SE loader (1).
REQ-007 addr0, addr1  input  ADDR_WIDTH each  burst start byte address, 16-byte aligned.
REQ-008 len0, len1  input  8 each  AXI arlen (beats-1).
REQ-009 gnt0, gnt1  output  1 each  one-cycle pulse when the requester's AR handshake completes.
REQ-010 rvalid0, rvalid1, rlast0, rlast1  output  1 each  per-requester data strobe and last-beat flag.
REQ-011 rdata  output  DATA_WIDTH  read data shared by both requesters, valid with rvalidN.
REQ-012 rerr0, rerr1  output  1 each  sticky error flag per requester.
REQ-013 arid_m_inf, araddr_m_inf, arlen_m_inf, arsize_m_inf, arburst_m_inf, arvalid_m_inf  output  ID_WIDTH/ADDR_WIDTH/8/3/2/1  AXI4 read address channel.
REQ-014 arready_m_inf  input  1  AXI4 read address ready.
REQ-015 rid_m_inf, rdata_m_inf, rresp_m_inf, rlast_m_inf, rvalid_m_inf  input  ID_WIDTH/DATA_WIDTH/2/1/1  AXI4 read data channel.
REQ-016 rready_m_inf  output  1  AXI4 read data ready.

Function
REQ-017 SHALL implement FSM IDLE -> ADDR -> DATA -> IDLE with at most one outstanding burst.
REQ-018 IDLE: if any reqN high, SHALL latch winner's addr/len/index and enter ADDR next cycle; else stay.
REQ-019 Arbitration SHALL be round-robin: on simultaneous req0 and req1, winner is the requester not granted last; after reset, requester 0 wins.
REQ-020 ADDR: arvalid_m_inf=1, araddr/arlen from latched values, arid=winner index zero-extended, arsize=3'b100, arburst=2'b01; values stable until arready_m_inf.
REQ-021 On arvalid&arready SHALL pulse gntN one cycle, update round-robin pointer, enter DATA.
REQ-022 DATA: rready_m_inf=1; each rvalid beat SHALL drive rdata=rdata_m_inf, rvalidN=1 and rlastN=rlast_m_inf combinationally, for N=latched winner only.
REQ-023 Beat with rlast_m_inf=1 SHALL return FSM to IDLE next cycle; new arbitration earliest that cycle (one idle bubble minimum between bursts).
REQ-024 SHALL count beats; rlast on beat != len+1, or beat len+1 without rlast, SHALL set rerrN.
REQ-025 rresp_m_inf != 2'b00 or rid_m_inf != latched index on any beat SHALL set rerrN; burst continues to completion.
REQ-026 addr[11:0] + 16*(len+1) > 4096 (4KB crossing) SHALL set rerrN at latch and the burst SHALL still be issued unchanged.
REQ-027 reqN SHALL be held until gntN; dropping it in ADDR SHALL NOT cancel the issued AR.
REQ-028 rerrN SHALL clear only on reset.
REQ-029 rready_m_inf SHALL be 0 and rvalid beats SHALL be ignored outside DATA.
REQ-030 All outputs in IDLE: arvalid=0, rready=0, gntN=0, rvalidN=0, rlastN=0.

Reset
REQ-031 rst_n low SHALL immediately force FSM IDLE, arvalid=0, rready=0, gnt/rvalid/rlast=0, rerr=0, araddr/arlen/arid=0, round-robin pointer to favour requester 0.
REQ-032 Reset mid-burst SHALL abandon the burst with no further gnt or rvalid pulses.

Verification
REQ-033 req0 alone, addr0=0x1000, len0=255, arready after 3 cycles -> one AR with arid=0, arlen=255; gnt0 pulse; 256 rvalid0 beats, rlast0 on beat 256; rerr0=0.
REQ-034 req0 and req1 in the same cycle, twice -> grant order 0,1 then 1,0 impossible; second pair order 0 then 1 only if pointer alternates: 0,1,0,1 across four bursts.
REQ-035 Burst to requester 1 with rresp=2'b10 on beat 2 -> rerr1=1 sticky, all beats still delivered, rerr0=0.
REQ-036 len0=3 but rlast on beat 2 -> rerr0=1, FSM returns IDLE after beat 2.
REQ-037 addr1=0x0FF0, len1=1 -> rerr1=1 (4KB crossing), AR still issued with araddr=0x0FF0.
REQ-038 rst_n pulsed low during DATA beat 10 -> outputs reset same cycle; next req0 after reset served normally from ADDR.
